// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode FND scan path.
// Segment codes are active-low {dp, g..a} with the decimal point off.
package fnd_pkg;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] COM_OFF   = 4'b1111;

    // Active-low digit enable: only bit idx is driven low.
    function automatic logic [3:0] digit_onehot_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational hex nibble to active-low g..a segment pattern.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK[6:0];
        case (i_nibble)
            4'h0: o_seg = SEG_0[6:0];
            4'h1: o_seg = SEG_1[6:0];
            4'h2: o_seg = SEG_2[6:0];
            4'h3: o_seg = SEG_3[6:0];
            4'h4: o_seg = SEG_4[6:0];
            4'h5: o_seg = SEG_5[6:0];
            4'h6: o_seg = SEG_6[6:0];
            4'h7: o_seg = SEG_7[6:0];
            4'h8: o_seg = SEG_8[6:0];
            4'h9: o_seg = SEG_9[6:0];
            4'hA: o_seg = SEG_A[6:0];
            4'hB: o_seg = SEG_B[6:0];
            4'hC: o_seg = SEG_C[6:0];
            4'hD: o_seg = SEG_D[6:0];
            4'hE: o_seg = SEG_E[6:0];
            4'hF: o_seg = SEG_F[6:0];
            default: o_seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-frame input latching,
// leading-zero blanking, per-digit decimal point and per-digit blink.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 4_000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    input  logic        blank_lz,
    output logic [3:0]  com,
    output logic [7:0]  seg_7,
    output logic        frame_done
);

    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCAN_W     = $clog2(SCAN_DIV);
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [15:0]        r_sh_value;
    logic [3:0]         r_sh_dp;
    logic [3:0]         r_sh_blink;
    logic               r_sh_blank_lz;
    logic [3:0]         r_com;
    logic [7:0]         r_seg;
    logic               r_frame_done;

    logic               w_scan_wrap;
    logic               w_frame_end;
    logic               w_blink_wrap;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg_hex;
    logic               w_lz_blank;
    logic               w_blink_blank;
    logic [7:0]         w_seg_nxt;

    assign w_scan_wrap  = (r_scan_cnt == SCAN_LAST);
    assign w_frame_end  = w_scan_wrap && (r_idx == 2'd3);
    assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Blink timebase free-runs; it is deliberately not aligned to the frame.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_blink_wrap) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_sh_value    <= 16'h0000;
            r_sh_dp       <= 4'b0000;
            r_sh_blink    <= 4'b0000;
            r_sh_blank_lz <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_sh_value    <= value;
                r_sh_dp       <= dp_mask;
                r_sh_blink    <= blink_mask;
                r_sh_blank_lz <= blank_lz;
            end
        end
    end

    assign w_nibble = r_sh_value[{r_idx, 2'b00} +: 4];

    fnd_seg_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hex)
    );

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd3: w_lz_blank = (r_sh_value[15:12] == 4'h0);
            2'd2: w_lz_blank = (r_sh_value[15:8]  == 8'h00);
            2'd1: w_lz_blank = (r_sh_value[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
        w_lz_blank = w_lz_blank && r_sh_blank_lz;
    end

    assign w_blink_blank = !r_blink_phase && r_sh_blink[r_idx];

    always_comb begin
        w_seg_nxt = {~r_sh_dp[r_idx], w_seg_hex};
        if (w_lz_blank || w_blink_blank)
            w_seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_com <= COM_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_com <= digit_onehot_n(r_idx);
            r_seg <= w_seg_nxt;
        end
    end

    assign com        = r_com;
    assign seg_7      = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV=4 and BLINK_HALF=20.
module tb_fnd_scan_ctrl;

    logic        clk;
    logic        reset_p;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic        frame_done;

    int n_vec;
    int n_err;
    int cyc;

    logic [7:0] hex_code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    fnd_scan_ctrl #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (250),
        .BLINK_HZ (25)
    ) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .value      (value),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .com        (com),
        .seg_7      (seg_7),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bm, input logic lz);
        value      = v;
        dp_mask    = dp;
        blink_mask = bm;
        blank_lz   = lz;
        reset_p    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        cyc     = 0;
    endtask

    function automatic int digit_of(input int c);
        return ((c - 1) / 4) % 4;
    endfunction

    task automatic test_reset();
        reset_p = 1'b0;
        #2;
        reset_p = 1'b1;
        #1;
        n_vec++;
        if (com !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_com got=%b exp=%b", com, 4'b1111);
        end
        n_vec++;
        if (seg_7 !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_seg got=%h exp=%h", seg_7, 8'hFF);
        end
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fd got=%b exp=0", frame_done);
        end
        do_reset(16'h1234, 4'h0, 4'h0, 1'b0);
        step();
        n_vec++;
        if (com !== 4'b1110 || seg_7 !== 8'hC0) begin
            n_err++;
            $display("FAIL first_cycle got=%b/%h exp=1110/c0", com, seg_7);
        end
    endtask

    task automatic test_scan_order();
        logic [15:0] v;
        logic [3:0]  exp_com;
        logic [7:0]  exp_seg;
        logic        exp_fd;
        int          d;
        v = 16'h1234;
        do_reset(v, 4'h0, 4'h0, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            step();
            d       = digit_of(cyc);
            exp_com = 4'b1111;
            exp_com[d] = 1'b0;
            exp_seg = (cyc <= 16) ? 8'hC0 : hex_code[v[d*4 +: 4]];
            exp_fd  = (cyc % 16 == 0);
            n_vec++;
            if (com !== exp_com) begin
                n_err++;
                $display("FAIL scan_com cyc=%0d got=%b exp=%b", cyc, com, exp_com);
            end
            n_vec++;
            if (seg_7 !== exp_seg) begin
                n_err++;
                $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seg_7, exp_seg);
            end
            n_vec++;
            if (frame_done !== exp_fd) begin
                n_err++;
                $display("FAIL scan_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] exp_a [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        logic [7:0] exp_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        do_reset(16'h0050, 4'h0, 4'h0, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            step();
            if (cyc == 32)
                value = 16'h0000;
            if (cyc >= 17 && cyc <= 32) begin
                n_vec++;
                if (seg_7 !== exp_a[digit_of(cyc)]) begin
                    n_err++;
                    $display("FAIL lz_0050 cyc=%0d got=%h exp=%h", cyc, seg_7,
                             exp_a[digit_of(cyc)]);
                end
            end
            if (cyc >= 49) begin
                n_vec++;
                if (seg_7 !== exp_b[digit_of(cyc)]) begin
                    n_err++;
                    $display("FAIL lz_0000 cyc=%0d got=%h exp=%h", cyc, seg_7,
                             exp_b[digit_of(cyc)]);
                end
            end
        end
    endtask

    task automatic test_no_tear();
        logic [7:0] exp_seg;
        do_reset(16'h1111, 4'h0, 4'h0, 1'b0);
        for (int k = 1; k <= 48; k++) begin
            step();
            if (cyc == 20)
                value = 16'h2222;
            if (cyc >= 17) begin
                exp_seg = (cyc <= 32) ? 8'hF9 : 8'hA4;
                n_vec++;
                if (seg_7 !== exp_seg) begin
                    n_err++;
                    $display("FAIL no_tear cyc=%0d got=%h exp=%h", cyc, seg_7, exp_seg);
                end
            end
            if (cyc == 32) begin
                n_vec++;
                if (frame_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL tear_fd cyc=%0d got=%b exp=1", cyc, frame_done);
                end
            end
        end
    endtask

    task automatic test_dp();
        logic [7:0] exp_seg;
        do_reset(16'h8888, 4'b0100, 4'h0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (cyc >= 17) begin
                exp_seg = (digit_of(cyc) == 2) ? 8'h00 : 8'h80;
                n_vec++;
                if (seg_7 !== exp_seg) begin
                    n_err++;
                    $display("FAIL dp cyc=%0d got=%h exp=%h", cyc, seg_7, exp_seg);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp_seg;
        logic       phase_prev;
        do_reset(16'h0000, 4'h0, 4'b0001, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (cyc >= 17) begin
                // output in this cycle reflects the blink phase held in the previous cycle
                phase_prev = (((cyc - 1) / 20) % 2 == 0);
                exp_seg = (digit_of(cyc) == 0 && !phase_prev) ? 8'hFF : 8'hC0;
                n_vec++;
                if (seg_7 !== exp_seg) begin
                    n_err++;
                    $display("FAIL blink cyc=%0d got=%h exp=%h", cyc, seg_7, exp_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(16'h1234, 4'b1111, 4'h0, 1'b0);
        for (int k = 1; k <= 26; k++)
            step();
        n_vec++;
        if (com !== 4'b1011 || seg_7 !== 8'h24) begin
            n_err++;
            $display("FAIL pre_reset got=%b/%h exp=1011/24", com, seg_7);
        end
        reset_p = 1'b1;
        #1;
        n_vec++;
        if (com !== 4'b1111 || seg_7 !== 8'hFF || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got=%b/%h/%b exp=1111/ff/0", com, seg_7, frame_done);
        end
        @(negedge clk);
        reset_p = 1'b0;
        cyc     = 0;
        step();
        n_vec++;
        if (com !== 4'b1110 || seg_7 !== 8'hC0) begin
            n_err++;
            $display("FAIL post_reset got=%b/%h exp=1110/c0", com, seg_7);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        reset_p    = 1'b0;
        value      = 16'h0000;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        blank_lz   = 1'b0;
        test_reset();
        test_scan_order();
        test_blanking();
        test_no_tear();
        test_dp();
        test_blink();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Four-digit multiplexed 7-segment scan controller. Sits directly downstream of the stopwatch/clock tops and consumes their 16-bit BCD/hex display word. Latches the word once per scan frame so digits never tear, then time-multiplexes the digits onto the common-anode FND. Adds leading-zero blanking, per-digit decimal point and per-digit blink.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 4_000, digit-advance rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit (must be ≥ 2).
- BLINK_HZ, 2, blink frequency; BLINK_HALF = CLK_HZ/(2*BLINK_HZ) cycles per phase.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  reset, asynchronous, active-high.
- value  in  16  display word; nibble 0 [3:0] = rightmost digit, nibble 3 = leftmost.
- dp_mask  in  4  bit i lights the decimal point of digit i.
- blink_mask  in  4  bit i makes digit i blink.
- blank_lz  in  1  enable leading-zero blanking.
- com  out  4  digit enables, active-low; com[i] drives digit i.
- seg_7  out  8  segments, active-low; [7] = dp, [6:0] = g..a.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Scan counter counts 0..SCAN_DIV-1 and wraps. Each wrap advances the digit index 0→1→2→3→0.
- Frame boundary is index 3→0. On that cycle:
  - value, dp_mask, blink_mask and blank_lz are copied into shadow registers.
  - frame_done pulses for one cycle.
- Input changes between boundaries have no effect on the display.
- Hex decode (active-low, g..a), by nibble 0..F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- Decimal point: seg_7[7] = ~shadow_dp[i].
- Leading-zero blanking (shadow blank_lz = 1):
  - Digit i ∈ {3,2,1} is blanked when shadow nibbles i..3 are all zero.
  - Digit 0 is never blanked.
- Blink:
  - Free-running counter toggles a blink phase every BLINK_HALF cycles. It is independent of the frame.
  - When the phase is 0 and shadow_blink[i] = 1, digit i is blanked.
- A blanked digit drives seg_7 = 8'hFF, including dp. Its com bit is still asserted in its slot.
- Exactly one com bit is low at all times after the first post-reset cycle.

## Timing
- Reset values:
  - com = 4'b1111, seg_7 = 8'hFF, frame_done = 0.
  - Scan counter, digit index and all shadows = 0.
  - Blink phase = 1 (visible); blink counter = 0.
- com and seg_7 are registered. They reflect the current index and shadow with 1-cycle latency.
- First clock after reset release: com = 4'b1110, seg_7 = 8'hC0.
- A digit is held for exactly SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- A new value becomes visible on digit 0 one cycle after the next frame boundary. Worst case is 4·SCAN_DIV + 1 cycles.
- frame_done asserts in the same cycle the shadows load. It is high while index changes 3→0.
- Simultaneous boundary and blink toggle: both take effect. The newly latched blink_mask combines with the new phase.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Scanning restarts from digit 0 with shadow 0.

## Structure
- Package fnd_pkg holds:
  - the 16 segment-code constants and SEG_BLANK = 8'hFF;
  - COM_OFF = 4'b1111;
  - function digit_onehot_n(idx) returning the active-low com pattern.
- Sub-module fnd_seg_decoder: combinational 4-bit nibble → 7-bit g..a, using fnd_pkg constants.
- Top module holds the scan counter, index, blink counter, shadows and output registers.

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=250 (SCAN_DIV=4), BLINK_HZ=25 (BLINK_HALF=20).
- Reset release with value=16'h1234, masks 0 → com cycles 1110, 1101, 1011, 0111 at 4 cycles each. The first frame shows 0,0,0,0 (C0). After the first frame_done it shows digits 4,3,2,1 (99, B0, A4, F9).
- value=16'h0050, blank_lz=1 → digit0=C0, digit1=92, digits 2 and 3 = FF. value=16'h0000 → only digit0 = C0.
- value changed mid-frame from 16'h1111 to 16'h2222 → no digit shows A4 until one cycle after frame_done, and all four then show A4 in the same frame.
- dp_mask=4'b0100, value=16'h8888 → digit2 seg_7=8'h00; the other digits show 8'h80.
- blink_mask=4'b0001 → digit0 shows FF in slots falling in blink phase 0 (cycles 20–39, 60–79, ...). Other digits are unaffected.
- reset_p asserted while digit 2 is active → same cycle com=1111, seg_7=FF, frame_done=0. After release, digit 0 shows C0.
